// File: rtl/freq_meter_pkg.sv
// Shared FSM state type and duty-cycle scaling constants for freq_duty_meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {IDLE, GATE, DIV} state_t;

    localparam int DUTY_SCALE = 10000;
    localparam int DUTY_W     = 16;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock. A start pulse loads the
// operands; done pulses NUM_W+1 cycles later and quotient holds until the next start.
module seq_divider #(
    parameter int NUM_W = 24,
    parameter int DEN_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic [NUM_W-1:0] quotient,
    output logic             done
);

    localparam int CNT_W = $clog2(NUM_W + 1);

    logic [NUM_W-1:0] q_work;
    logic [DEN_W-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic [DEN_W:0]   rem_sh;
    logic [DEN_W-1:0] rem_sub;
    logic             ge;
    logic [NUM_W-1:0] q_next;

    // The partial remainder stays below den, so DEN_W+1 bits hold the shifted value.
    always_comb begin
        rem_sh  = {rem, q_work[NUM_W-1]};
        ge      = (rem_sh >= {1'b0, den});
        rem_sub = rem_sh[DEN_W-1:0] - den;
        q_next  = {q_work[NUM_W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_work   <= '0;
            rem      <= '0;
            cnt      <= '0;
            running  <= 1'b0;
            quotient <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                q_work  <= num;
                rem     <= '0;
                cnt     <= CNT_W'(NUM_W);
                running <= 1'b1;
            end else if (running) begin
                rem    <= ge ? rem_sub : rem_sh[DEN_W-1:0];
                q_work <= q_next;
                cnt    <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    running  <= 1'b0;
                    done     <= 1'b1;
                    quotient <= q_next;
                end
            end
        end
    end

endmodule

// File: rtl/freq_duty_meter.sv
// Gated frequency and duty-cycle meter for sig_in. Define FREQ_METER_DUTY_EN to
// build the duty path (high counter, divider, DIV state); otherwise duty outputs are 0.
module freq_duty_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CW          = $clog2(GATE_CYCLES + 1)
) (
    input  logic              freq_source,
    input  logic              rst,
    input  logic              sig_in,
    input  logic              meas_en,
    output logic [31:0]       freq_data,
    output logic              freq_valid,
    output logic [DUTY_W-1:0] duty_data,
    output logic              duty_valid,
    output logic              busy
);

    logic          s_meta, s_sync, s_dly, rise;
    state_t        state;
    logic [CW-1:0] gate_cnt, edge_cnt, edge_nxt;

    assign rise     = s_sync & ~s_dly;
    assign edge_nxt = edge_cnt + CW'(rise);
    assign busy     = (state != IDLE);

    always_ff @(posedge freq_source) begin
        if (rst) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
            s_dly  <= 1'b0;
        end else begin
            s_meta <= sig_in;
            s_sync <= s_meta;
            s_dly  <= s_sync;
        end
    end

`ifdef FREQ_METER_DUTY_EN
    localparam int NUM_W = CW + 14;

    logic [CW-1:0]    high_cnt, high_nxt;
    logic [NUM_W-1:0] div_num, div_q;
    logic             div_start, div_done;
    logic             unused_q;

    assign high_nxt = high_cnt + CW'(s_sync);
    // high_cnt is frozen through DIV, so the numerator is stable when start fires.
    assign div_num  = NUM_W'(high_cnt) * NUM_W'(DUTY_SCALE);
    assign unused_q = &{1'b0, div_q[NUM_W-1:DUTY_W]};

    seq_divider #(
        .NUM_W(NUM_W),
        .DEN_W(CW)
    ) u_div (
        .clk     (freq_source),
        .rst     (rst),
        .start   (div_start),
        .num     (div_num),
        .den     (CW'(GATE_CYCLES)),
        .quotient(div_q),
        .done    (div_done)
    );
`else
    logic rearm;

    assign duty_data  = '0;
    assign duty_valid = 1'b0;
`endif

    always_ff @(posedge freq_source) begin
        if (rst) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            freq_data  <= '0;
            freq_valid <= 1'b0;
`ifdef FREQ_METER_DUTY_EN
            high_cnt   <= '0;
            duty_data  <= '0;
            duty_valid <= 1'b0;
            div_start  <= 1'b0;
`else
            rearm      <= 1'b0;
`endif
        end else begin
            freq_valid <= 1'b0;
`ifdef FREQ_METER_DUTY_EN
            duty_valid <= 1'b0;
            div_start  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
`ifdef FREQ_METER_DUTY_EN
                    high_cnt <= '0;
`endif
                    if (meas_en) state <= GATE;
                end
                GATE: begin
                    if (!meas_en) begin
                        state    <= IDLE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
`ifdef FREQ_METER_DUTY_EN
                        high_cnt <= '0;
`else
                        rearm    <= 1'b0;
`endif
                    end
`ifndef FREQ_METER_DUTY_EN
                    // One idle turnaround cycle between back-to-back gates.
                    else if (rearm) begin
                        rearm <= 1'b0;
                    end
`endif
                    else if (gate_cnt == CW'(GATE_CYCLES - 1)) begin
                        freq_data  <= 32'(edge_nxt);
                        freq_valid <= 1'b1;
`ifdef FREQ_METER_DUTY_EN
                        edge_cnt   <= edge_nxt;
                        high_cnt   <= high_nxt;
                        div_start  <= 1'b1;
                        state      <= DIV;
`else
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        rearm      <= 1'b1;
`endif
                    end else begin
                        gate_cnt <= gate_cnt + CW'(1);
                        edge_cnt <= edge_nxt;
`ifdef FREQ_METER_DUTY_EN
                        high_cnt <= high_nxt;
`endif
                    end
                end
`ifdef FREQ_METER_DUTY_EN
                DIV: begin
                    if (div_done) begin
                        duty_data  <= div_q[DUTY_W-1:0];
                        duty_valid <= 1'b1;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        high_cnt   <= '0;
                        state      <= meas_en ? GATE : IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_duty_meter.sv
// Scoreboard bench for freq_duty_meter with a 1000-cycle gate; expected results are
// queued by the stimulus and consumed by a monitor on every valid pulse.
`timescale 1ns/1ps
module tb_freq_duty_meter;
    import freq_meter_pkg::*;

    localparam int GATE_CYCLES = 1000;
`ifdef FREQ_METER_DUTY_EN
    // 1000 gate cycles + start cycle + 24 divide steps + done cycle
    localparam int PERIOD    = 1026;
    localparam int DUTY_LAG  = 26;
    localparam int HOLD_DUTY = 5000;
`else
    localparam int PERIOD    = 1001;
    localparam int HOLD_DUTY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig_in = 1'b0;
    logic        meas_en = 1'b0;
    logic [31:0] freq_data;
    logic        freq_valid;
    logic [15:0] duty_data;
    logic        duty_valid;
    logic        busy;

    int total = 0, bad = 0;
    int nfreq = 0, nduty = 0;
    int cyc = 0, fv_last = 0, fv_prev = 0, dv_last = 0;
    int fq[$];
    int dq[$];
    int gen_period = 10, gen_high = 5, phase = 0;

    freq_duty_meter #(.GATE_CYCLES(GATE_CYCLES)) dut (
        .freq_source(clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .meas_en    (meas_en),
        .freq_data  (freq_data),
        .freq_valid (freq_valid),
        .duty_data  (duty_data),
        .duty_valid (duty_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Periodic test signal: gen_high cycles high out of every gen_period.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            phase  = (phase + 1 >= gen_period) ? 0 : phase + 1;
            sig_in = (phase < gen_high);
        end
    end

    always @(negedge clk) begin
        if (freq_valid && duty_valid) check("valid_overlap", 1, 0);
        if (freq_valid) begin
            if (fq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_freq_valid: got freq_data=%0d with no result expected", freq_data);
            end else begin
                check("freq_data", freq_data, fq.pop_front());
            end
            nfreq++;
            fv_prev = fv_last;
            fv_last = cyc;
        end
        if (duty_valid) begin
            if (dq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_duty_valid: got duty_data=%0d with no result expected", duty_data);
            end else begin
                check("duty_data", duty_data, dq.pop_front());
            end
            nduty++;
            dv_last = cyc;
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            tick(1);
            n++;
        end
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic wait_freq(input string name, input int target, input int limit);
        int n = 0;
        while (nfreq < target && n < limit) begin
            tick(1);
            n++;
        end
        check({name, "_freq_timeout"}, (nfreq >= target), 1);
    endtask

    task automatic run(input string name, input int per, input int hi, input int ng,
                       input int ef, input int ed);
        int target;
        meas_en = 1'b0;
        wait_idle({name, "_pre"});
        gen_period = per;
        gen_high   = hi;
        tick(6);
        for (int i = 0; i < ng; i++) begin
            fq.push_back(ef);
`ifdef FREQ_METER_DUTY_EN
            dq.push_back(ed);
`endif
        end
        target  = nfreq + ng;
        meas_en = 1'b1;
        wait_freq(name, target, ng * 1100 + 50);
        meas_en = 1'b0;
        wait_idle(name);
        tick(2);
`ifdef FREQ_METER_DUTY_EN
        check({name, "_duty_lag"}, dv_last - fv_last, DUTY_LAG);
`endif
        check({name, "_queue_empty"}, fq.size() + dq.size(), 0);
    endtask

    initial begin
        int n;
        int target;

        tick(3);
        check("rst_freq_data", freq_data, 0);
        check("rst_duty_data", duty_data, 0);
        check("rst_freq_valid", freq_valid, 0);
        check("rst_duty_valid", duty_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick(2);

        run("p10", 10, 5, 2, 100, 5000);
        check("p10_gate_period", fv_last - fv_prev, PERIOD);
        run("p8", 8, 3, 1, 125, 3750);
        run("stuck_high", 10, 10, 1, 0, 10000);
        run("stuck_low", 10, 0, 1, 0, 0);
        run("p10b", 10, 5, 1, 100, 5000);

        // Abort half-way through a gate: nothing published, outputs keep 100/5000.
        meas_en = 1'b1;
        n = 0;
        while (!busy && n < 10) begin
            tick(1);
            n++;
        end
        check("abort_busy_rise", busy, 1);
        tick(500);
        meas_en = 1'b0;
        tick(2);
        check("abort_busy", busy, 0);
        check("abort_state", int'(dut.state), int'(IDLE));
        check("abort_freq_hold", freq_data, 100);
        check("abort_duty_hold", duty_data, HOLD_DUTY);
        tick(40);

        // Reset shortly after the gate closes; the pending duty result must vanish.
        fq.push_back(100);
        target  = nfreq + 1;
        meas_en = 1'b1;
        wait_freq("rst_mid", target, 1150);
        tick(4);
        rst     = 1'b1;
        meas_en = 1'b0;
        tick(1);
        rst = 1'b0;
        check("rst_mid_freq_data", freq_data, 0);
        check("rst_mid_duty_data", duty_data, 0);
        check("rst_mid_freq_valid", freq_valid, 0);
        check("rst_mid_duty_valid", duty_valid, 0);
        check("rst_mid_busy", busy, 0);
        tick(40);
        check("rst_mid_duty_count", nduty, 4 * int'(HOLD_DUTY != 0) + int'(HOLD_DUTY != 0) + int'(HOLD_DUTY != 0));

        fq.push_back(100);
`ifdef FREQ_METER_DUTY_EN
        dq.push_back(5000);
`endif
        target  = nfreq + 1;
        meas_en = 1'b1;
        wait_freq("post_rst", target, 1150);
        meas_en = 1'b0;
        wait_idle("post_rst");
        tick(2);
        check("post_rst_queue_empty", fq.size() + dq.size(), 0);
        check("post_rst_duty_data", duty_data, HOLD_DUTY);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
